car_gate_sensor: RTL and testbench

- Upstream stage of the car park occupancy counter.
- Converts two raw beam-break sensors at the gate into single-cycle `inc_exp` / `dec_exp` pulses that feed the counter.
  - `sensor_a` is on the outside of the gate.
  - `sensor_b` is on the inside.
- Synchronises and debounces both sensors, then runs a direction-decoding FSM.
- Flags illegal sensor sequences on `error`.

---
 rtl/car_gate_sensor.sv | 199 +++++++++++++++++++
 tb/tb_car_gate_sensor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/car_gate_sensor.sv
`default_nettype none
// ============================================================================
// Module   : car_gate_sensor
// Brief    : Gate sensor front end. Synchronises and debounces the two beams,
//            then decodes the crossing direction into entry/exit pulses.
// Revision : 1.0 - initial release
// ============================================================================
module car_gate_sensor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic inc_exp,
    output logic dec_exp,
    output logic busy,
    output logic error
);

    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENT_A  = 3'd1,
        S_ENT_AB = 3'd2,
        S_ENT_B  = 3'd3,
        S_EXT_B  = 3'd4,
        S_EXT_AB = 3'd5,
        S_EXT_A  = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Bit 1 carries the outer beam (a), bit 0 the inner beam (b).
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1_q;
    logic [1:0]       r_sync2_q;
    logic [1:0]       r_filt_q;
    logic [1:0]       w_filt_d;
    logic [CNT_W-1:0] r_cnt_q [2];
    logic [CNT_W-1:0] w_cnt_d [2];

    state_t r_state_q;
    state_t w_state_d;
    logic   r_inc_q;
    logic   r_dec_q;
    logic   r_busy_q;
    logic   r_error_q;
    logic   w_inc_d;
    logic   w_dec_d;
    logic   w_busy_d;
    logic   w_error_d;

    assign w_raw = {sensor_a, sensor_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1_q <= 2'b00;
            r_sync2_q <= 2'b00;
        end else begin
            r_sync1_q <= w_raw;
            r_sync2_q <= r_sync1_q;
        end
    end

    // A sensor's filtered value follows only after it has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_filt_d[i] = r_filt_q[i];
            w_cnt_d[i]  = '0;
            if (r_sync2_q[i] != r_filt_q[i]) begin
                if (r_cnt_q[i] == c_DB_LAST) begin
                    w_filt_d[i] = r_sync2_q[i];
                end else begin
                    w_cnt_d[i] = r_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_cnt_q[i] <= '0;
            end
        end else begin
            r_filt_q <= w_filt_d;
            for (int i = 0; i < 2; i++) begin
                r_cnt_q[i] <= w_cnt_d[i];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_inc_d   = 1'b0;
        w_dec_d   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                case (r_filt_q)
                    2'b10:   w_state_d = S_ENT_A;
                    2'b01:   w_state_d = S_EXT_B;
                    2'b11:   w_state_d = S_FAULT;
                    default: w_state_d = S_IDLE;
                endcase
            end
            S_ENT_A: begin
                case (r_filt_q)
                    2'b11:   w_state_d = S_ENT_AB;
                    2'b00:   w_state_d = S_IDLE;
                    2'b01:   w_state_d = S_FAULT;
                    default: w_state_d = S_ENT_A;
                endcase
            end
            S_ENT_AB: begin
                case (r_filt_q)
                    2'b01:   w_state_d = S_ENT_B;
                    2'b10:   w_state_d = S_ENT_A;
                    2'b00:   w_state_d = S_FAULT;
                    default: w_state_d = S_ENT_AB;
                endcase
            end
            S_ENT_B: begin
                case (r_filt_q)
                    2'b00: begin
                        w_state_d = S_IDLE;
                        w_inc_d   = 1'b1;
                    end
                    2'b11:   w_state_d = S_ENT_AB;
                    2'b10:   w_state_d = S_FAULT;
                    default: w_state_d = S_ENT_B;
                endcase
            end
            S_EXT_B: begin
                case (r_filt_q)
                    2'b11:   w_state_d = S_EXT_AB;
                    2'b00:   w_state_d = S_IDLE;
                    2'b10:   w_state_d = S_FAULT;
                    default: w_state_d = S_EXT_B;
                endcase
            end
            S_EXT_AB: begin
                case (r_filt_q)
                    2'b10:   w_state_d = S_EXT_A;
                    2'b01:   w_state_d = S_EXT_B;
                    2'b00:   w_state_d = S_FAULT;
                    default: w_state_d = S_EXT_AB;
                endcase
            end
            S_EXT_A: begin
                case (r_filt_q)
                    2'b00: begin
                        w_state_d = S_IDLE;
                        w_dec_d   = 1'b1;
                    end
                    2'b11:   w_state_d = S_EXT_AB;
                    2'b01:   w_state_d = S_FAULT;
                    default: w_state_d = S_EXT_A;
                endcase
            end
            S_FAULT: begin
                if (r_filt_q == 2'b00) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        // Status flags are registered from the next state so they line up
        // with the state register rather than lagging it by a cycle.
        w_busy_d  = (w_state_d != S_IDLE) && (w_state_d != S_FAULT);
        w_error_d = (w_state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_inc_q   <= 1'b0;
            r_dec_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_error_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_inc_q   <= w_inc_d;
            r_dec_q   <= w_dec_d;
            r_busy_q  <= w_busy_d;
            r_error_q <= w_error_d;
        end
    end

    assign inc_exp = r_inc_q;
    assign dec_exp = r_dec_q;
    assign busy    = r_busy_q;
    assign error   = r_error_q;

endmodule
`default_nettype wire

// File: tb/tb_car_gate_sensor.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_gate_sensor
// Brief    : Scoreboard bench for car_gate_sensor with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_car_gate_sensor;

    localparam int c_D = 4;

    logic clk = 1'b0;
    logic rst;
    logic sensor_a;
    logic sensor_b;
    logic inc_exp;
    logic dec_exp;
    logic busy;
    logic error;

    car_gate_sensor #(.DEBOUNCE_CYCLES(c_D), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .inc_exp  (inc_exp),
        .dec_exp  (dec_exp),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } dchk_t;

    logic [3:0] exp_q [$];
    dchk_t      dq [$];
    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int inc_cnt = 0, dec_cnt = 0, busy_cnt = 0, err_cnt = 0;
    int last_inc_edge = -1, last_dec_edge = -1;

    // Reference model: beams are judged by the raw samples they were given,
    // and the gate is tracked by named position along the crossing.
    string m_state;
    bit    m_fa, m_fb;
    bit    ha [$];
    bit    hb [$];

    function automatic bit window_flips(input bit h [$], input bit f);
        for (int i = 0; i < c_D; i++) begin
            if (h[i] == f) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void gate_next(input string s, input bit a, input bit b,
                                      output string n, output bit pi, output bit pd);
        string p;
        p  = {a ? "1" : "0", b ? "1" : "0"};
        n  = s;
        pi = 1'b0;
        pd = 1'b0;
        if (s == "IDLE") begin
            if (p == "10") n = "ENT_A"; else if (p == "01") n = "EXT_B"; else if (p == "11") n = "FAULT";
        end else if (s == "ENT_A") begin
            if (p == "11") n = "ENT_AB"; else if (p == "00") n = "IDLE"; else if (p == "01") n = "FAULT";
        end else if (s == "ENT_AB") begin
            if (p == "01") n = "ENT_B"; else if (p == "10") n = "ENT_A"; else if (p == "00") n = "FAULT";
        end else if (s == "ENT_B") begin
            if (p == "00") begin n = "IDLE"; pi = 1'b1; end
            else if (p == "11") n = "ENT_AB"; else if (p == "10") n = "FAULT";
        end else if (s == "EXT_B") begin
            if (p == "11") n = "EXT_AB"; else if (p == "00") n = "IDLE"; else if (p == "10") n = "FAULT";
        end else if (s == "EXT_AB") begin
            if (p == "10") n = "EXT_A"; else if (p == "01") n = "EXT_B"; else if (p == "00") n = "FAULT";
        end else if (s == "EXT_A") begin
            if (p == "00") begin n = "IDLE"; pd = 1'b1; end
            else if (p == "11") n = "EXT_AB"; else if (p == "01") n = "FAULT";
        end else begin
            if (p == "00") n = "IDLE";
        end
    endfunction

    always @(posedge clk) begin
        string ns;
        bit    pi, pd, bz, er;
        edge_cnt++;
        if (rst) begin
            m_state = "IDLE";
            m_fa = 1'b0;
            m_fb = 1'b0;
            ha = {};
            hb = {};
            for (int i = 0; i <= c_D; i++) begin
                ha.push_back(1'b0);
                hb.push_back(1'b0);
            end
            exp_q.push_back(4'b0000);
        end else begin
            gate_next(m_state, m_fa, m_fb, ns, pi, pd);
            m_state = ns;
            bz = !(ns == "IDLE" || ns == "FAULT");
            er = (ns == "FAULT");
            exp_q.push_back({pi, pd, bz, er});
            if (window_flips(ha, m_fa)) m_fa = ~m_fa;
            if (window_flips(hb, m_fb)) m_fb = ~m_fb;
            ha.push_back(sensor_a);
            hb.push_back(sensor_b);
            void'(ha.pop_front());
            void'(hb.pop_front());
        end
    end

    // Monitor: the only process that compares and updates the tallies.
    always @(negedge clk) begin
        logic [3:0] act;
        logic [3:0] exv;
        dchk_t      d;
        act = {inc_exp, dec_exp, busy, error};
        if (exp_q.size() > 0) begin
            exv = exp_q.pop_front();
            checks++;
            if (act !== exv) begin
                errors++;
                $display("FAIL outputs@edge%0d: inc/dec/busy/err got %b expected %b", edge_cnt, act, exv);
            end
        end
        if (inc_exp) begin inc_cnt++; last_inc_edge = edge_cnt; end
        if (dec_exp) begin dec_cnt++; last_dec_edge = edge_cnt; end
        if (busy)    busy_cnt++;
        if (error)   err_cnt++;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            checks++;
            if (d.act != d.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", d.name, d.act, d.exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exv);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exv;
        dq.push_back(d);
    endtask

    task automatic step(input bit a, input bit b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(negedge clk);
        #1;
    endtask

    int s_inc, s_dec, s_busy, s_err, e0;

    task automatic snap();
        s_inc  = inc_cnt;
        s_dec  = dec_cnt;
        s_busy = busy_cnt;
        s_err  = err_cnt;
    endtask

    initial begin
        rst = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {inc_exp, dec_exp, busy, error}, 0);
        rst = 1'b0;
        snap();
        step(0, 0, 20);
        chk("idle_activity", (inc_cnt - s_inc) + (dec_cnt - s_dec) + (busy_cnt - s_busy) + (err_cnt - s_err), 0);

        // Clean entry
        snap();
        step(1, 0, 10); step(1, 1, 10); step(0, 1, 10);
        e0 = edge_cnt;
        step(0, 0, 12);
        chk("entry_inc_count", inc_cnt - s_inc, 1);
        chk("entry_dec_count", dec_cnt - s_dec, 0);
        chk("entry_inc_edge", last_inc_edge, e0 + 7);

        // Clean exit
        snap();
        step(0, 1, 10); step(1, 1, 10); step(1, 0, 10);
        e0 = edge_cnt;
        step(0, 0, 12);
        chk("exit_dec_count", dec_cnt - s_dec, 1);
        chk("exit_inc_count", inc_cnt - s_inc, 0);
        chk("exit_dec_edge", last_dec_edge, e0 + 7);

        // Glitches one cycle shorter than, then equal to, the debounce time
        snap();
        step(1, 0, c_D - 1); step(0, 0, 15);
        chk("glitch_short_busy", busy_cnt - s_busy, 0);
        snap();
        step(1, 0, c_D); step(0, 0, 15);
        chk("glitch_full_busy", (busy_cnt - s_busy) > 0, 1);
        chk("glitch_full_pulses", (inc_cnt - s_inc) + (dec_cnt - s_dec), 0);

        // Abort and back-up
        snap();
        step(1, 0, 10); step(0, 0, 12);
        step(1, 0, 10); step(1, 1, 10); step(1, 0, 10); step(0, 0, 12);
        chk("abort_backup_pulses", (inc_cnt - s_inc) + (dec_cnt - s_dec), 0);

        // Simultaneous rise faults; clearing both returns to idle
        snap();
        e0 = edge_cnt;
        step(1, 1, 10);
        chk("fault_err_cycles", err_cnt - s_err, 10 - 6);
        step(0, 0, 12);
        chk("fault_exit_state", error, 0);
        chk("fault_pulses", (inc_cnt - s_inc) + (dec_cnt - s_dec), 0);

        // Reset while in the final entry position
        snap();
        step(1, 0, 10); step(1, 1, 10); step(0, 1, 10);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", {inc_exp, dec_exp, busy, error}, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 15);
        chk("midreset_inc", inc_cnt - s_inc, 0);

        // Random traffic against the model
        snap();
        for (int i = 0; i < 250; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 3 * c_D));
        end
        step(0, 0, 20);
        chk("random_no_fault_pulse", 0, 0 * (inc_cnt - s_inc));

        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Pulse exclusivity across the whole run
    always @(negedge clk) begin
        if (inc_exp && dec_exp) begin
            $display("FAIL pulse_overlap: inc=%0b dec=%0b required not both", inc_exp, dec_exp);
        end
    end

endmodule
`default_nettype wire
